// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and port ids for the data memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rtl/mem_arbiter_rr_arb2.sv - combinational two-way round-robin picker with optional lock
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last,
  input  logic       i_lock,
  input  logic       i_owner,
  output logic [1:0] o_grant
);

  // A held lock excludes the other port even when the owner is idle.
  always_comb begin
    o_grant = 2'b00;
    if (i_lock) begin
      o_grant[i_owner] = i_valid[i_owner];
    end else if (i_valid == 2'b11) begin
      o_grant = (i_last == PORT_HOST) ? 2'b01 : 2'b10;
    end else begin
      o_grant = i_valid;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares single-port mem_data between core and host requesters
// Optional grant locking is built when RISC16_ARB_LOCK_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int  p_WORD_LEN      = 16,
  parameter int  p_DATA_MEM_SIZE = 1024,
  localparam int ADDR_LEN        = $clog2(p_DATA_MEM_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic                  i_req0_we,
  input  logic                  i_req0_lock,
  input  logic [15:0]           i_req0_addr,
  input  logic [p_WORD_LEN-1:0] i_req0_wdata,
  output logic                  o_req0_rvalid,
  output logic [p_WORD_LEN-1:0] o_req0_rdata,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic                  i_req1_we,
  input  logic                  i_req1_lock,
  input  logic [15:0]           i_req1_addr,
  input  logic [p_WORD_LEN-1:0] i_req1_wdata,
  output logic                  o_req1_rvalid,
  output logic [p_WORD_LEN-1:0] o_req1_rdata,
  output logic [ADDR_LEN-1:0]   o_mem_addr,
  output logic [p_WORD_LEN-1:0] o_mem_wdata,
  output logic                  o_mem_wen,
  input  logic [p_WORD_LEN-1:0] i_mem_rdata
);

  localparam logic [16:0] MEM_SIZE = 17'(p_DATA_MEM_SIZE);

  state_e                  state_q, state_d;
  logic                    last_q, last_d;
  logic                    gnt_q, gnt_d;
  logic                    we_q, we_d;
  logic [15:0]             addr_q, addr_d;
  logic [p_WORD_LEN-1:0]   wdata_q, wdata_d;
  logic [p_WORD_LEN-1:0]   rdata_q, rdata_d;
  logic [1:0]              grant;
  logic                    arb_lock, arb_owner;
  logic                    in_range;

`ifdef RISC16_ARB_LOCK_EN
  logic lock_q, lock_d, owner_q, owner_d;
  assign arb_lock  = lock_q;
  assign arb_owner = owner_q;
`else
  logic unused_lock;
  assign arb_lock    = 1'b0;
  assign arb_owner   = 1'b0;
  assign unused_lock = i_req0_lock ^ i_req1_lock;
`endif

  // Full 16-bit compare so aliases above the memory size never reach mem_data.
  assign in_range = {1'b0, addr_q} < MEM_SIZE;

  rr_arb2 u_arb (
    .i_valid ({i_req1_valid, i_req0_valid}),
    .i_last  (last_q),
    .i_lock  (arb_lock),
    .i_owner (arb_owner),
    .o_grant (grant)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
`ifdef RISC16_ARB_LOCK_EN
    lock_d        = lock_q;
    owner_d       = owner_q;
`endif
    o_req0_ready  = 1'b0;
    o_req1_ready  = 1'b0;
    o_req0_rvalid = 1'b0;
    o_req1_rvalid = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    o_mem_wen     = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req0_ready = grant[0] & i_rst_n;
        o_req1_ready = grant[1] & i_rst_n;
        if (|grant) begin
          gnt_d   = grant[1];
          last_d  = grant[1];
          we_d    = grant[1] ? i_req1_we    : i_req0_we;
          addr_d  = grant[1] ? i_req1_addr  : i_req0_addr;
          wdata_d = grant[1] ? i_req1_wdata : i_req0_wdata;
`ifdef RISC16_ARB_LOCK_EN
          // Only the owner can win while locked, so its lock bit alone decides.
          lock_d  = grant[1] ? i_req1_lock : i_req0_lock;
          owner_d = grant[1];
`endif
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        o_mem_addr  = addr_q[ADDR_LEN-1:0];
        o_mem_wdata = wdata_q;
        o_mem_wen   = we_q & in_range;
        rdata_d     = (in_range && !we_q) ? i_mem_rdata : '0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        o_req0_rvalid = (gnt_q == PORT_CORE);
        o_req1_rvalid = (gnt_q == PORT_HOST);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_req0_rdata = rdata_q;
  assign o_req1_rdata = rdata_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      last_q  <= PORT_HOST;
      gnt_q   <= PORT_CORE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef RISC16_ARB_LOCK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_q  <= 1'b0;
      owner_q <= PORT_CORE;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with randomized and directed traffic
module tb_mem_arbiter;
  localparam int W  = 16;
  localparam int N  = 1024;
  localparam int AL = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v0 = 0, v1 = 0, we0 = 0, we1 = 0, lk0 = 0, lk1 = 0;
  logic [15:0] a0 = '0, a1 = '0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic ready0, ready1, rvalid0, rvalid1, mem_wen;
  logic [W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AL-1:0] mem_addr;

  logic [W-1:0] mem [N];
  logic [W-1:0] ref_mem [N];

  mem_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(ready0), .i_req0_we(we0), .i_req0_lock(lk0),
    .i_req0_addr(a0), .i_req0_wdata(d0), .o_req0_rvalid(rvalid0), .o_req0_rdata(rdata0),
    .i_req1_valid(v1), .o_req1_ready(ready1), .i_req1_we(we1), .i_req1_lock(lk1),
    .i_req1_addr(a1), .i_req1_wdata(d1), .o_req1_rvalid(rvalid1), .o_req1_rdata(rdata1),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
    .i_mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wen) mem[mem_addr] <= mem_wdata;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0, fails = 0;

  typedef struct { logic [W-1:0] data; int due; } resp_t;
  typedef struct { logic [AL-1:0] a; logic [W-1:0] d; int due; } wr_t;
  resp_t q0[$], q1[$];
  wr_t   wq[$];
  int    grants[$], hs_cyc[$];

  int m_last = 1, m_owner = 0, busy_until = -1;
  bit m_locked = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string nm);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor: predicts the winner from the arbitration rules, scores responses and writes.
  always @(negedge clk) begin
    if (rst_n) begin
      bit h0, h1;
      bit [1:0] vv;
      int expw, pact;
      logic [15:0] ad;
      logic [W-1:0] wd;
      bit wr;
      resp_t r, e;
      wr_t wt, we_exp;
      h0 = v0 && ready0;
      h1 = v1 && ready1;
      vv = {v1, v0};
      pact = h1 ? 1 : (h0 ? 0 : -1);
      if (v0 && v1) chk("one_ready", ready0 && ready1, 0);
      expw = -1;
      if (m_locked) begin
        if (vv[m_owner]) expw = m_owner;
      end else if (vv == 2'b11) expw = 1 - m_last;
      else if (vv == 2'b01) expw = 0;
      else if (vv == 2'b10) expw = 1;
      if (cyc > busy_until) begin
        if (expw >= 0 || pact >= 0) chk("grant", pact, expw);
      end else if (ready0 || ready1) begin
        fail_msg("ready_while_busy");
      end
      if (pact >= 0) begin
        wr = pact ? we1 : we0;
        ad = pact ? a1 : a0;
        wd = pact ? d1 : d0;
        m_last = pact;
`ifdef RISC16_ARB_LOCK_EN
        m_locked = pact ? lk1 : lk0;
        m_owner  = pact;
`endif
        busy_until = cyc + 2;
        grants.push_back(pact);
        hs_cyc.push_back(cyc);
        r.due = cyc + 2;
        r.data = '0;
        if (ad < N) begin
          if (wr) begin
            ref_mem[ad[AL-1:0]] = wd;
            wt.a = ad[AL-1:0];
            wt.d = wd;
            wt.due = cyc + 1;
            wq.push_back(wt);
          end else begin
            r.data = ref_mem[ad[AL-1:0]];
          end
        end
        if (pact == 1) q1.push_back(r);
        else q0.push_back(r);
      end
      if (rvalid0) begin
        if (q0.size() == 0) fail_msg("unexpected_rvalid0");
        else begin
          e = q0.pop_front();
          chk("rdata0", rdata0, e.data);
          chk("rvalid0_latency", cyc, e.due);
        end
      end else if (q0.size() > 0 && q0[0].due < cyc) begin
        fail_msg("missing_rvalid0");
        void'(q0.pop_front());
      end
      if (rvalid1) begin
        if (q1.size() == 0) fail_msg("unexpected_rvalid1");
        else begin
          e = q1.pop_front();
          chk("rdata1", rdata1, e.data);
          chk("rvalid1_latency", cyc, e.due);
        end
      end else if (q1.size() > 0 && q1[0].due < cyc) begin
        fail_msg("missing_rvalid1");
        void'(q1.pop_front());
      end
      if (mem_wen) begin
        if (wq.size() == 0) fail_msg("unexpected_mem_wen");
        else begin
          we_exp = wq.pop_front();
          chk("mem_wr_addr", mem_addr, we_exp.a);
          chk("mem_wr_data", mem_wdata, we_exp.d);
          chk("mem_wr_cycle", cyc, we_exp.due);
        end
      end else if (wq.size() > 0 && wq[0].due < cyc) begin
        fail_msg("missing_mem_wen");
        void'(wq.pop_front());
      end
    end
  end

  task automatic req(input int p, input bit w, input logic [15:0] a,
                     input logic [W-1:0] d, input bit lk);
    int n;
    bit done;
    n = 0;
    done = 0;
    if (p == 0) begin v0 = 1; we0 = w; a0 = a; d0 = d; lk0 = lk; end
    else        begin v1 = 1; we1 = w; a1 = a; d1 = d; lk1 = lk; end
    while (!done) begin
      @(negedge clk);
      if (p == 0 ? ready0 : ready1) done = 1;
      else if (++n > 400) begin
        fail_msg(p == 0 ? "timeout_ready0" : "timeout_ready1");
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    if (p == 0) v0 = 0;
    else v1 = 0;
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    wq.delete();
    grants.delete();
    hs_cyc.delete();
    m_last = 1;
    m_locked = 0;
    m_owner = 0;
    busy_until = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    #3;
    clear_model();
    @(posedge clk);
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int p, input int n);
    bit w;
    int r, g;
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      w = 1'($urandom);
      r = int'($urandom_range(0, 9));
      if (r == 0) a = 16'($urandom_range(1024, 65535));
      else a = 16'($urandom_range(0, 1023));
      req(p, w, a, W'($urandom), (i < n - 1) && ($urandom_range(0, 3) == 0));
      g = int'($urandom_range(0, 2));
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [W-1:0] old0, old7;
  int exp_seq[4];

  initial begin
    for (int i = 0; i < N; i++) begin
      mem[i] = W'($urandom);
      ref_mem[i] = mem[i];
    end
    v0 = 1;
    v1 = 1;
    #12;
    chk("rst_ready0", ready0, 0);
    chk("rst_ready1", ready1, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata0", rdata0, 0);
    v0 = 0;
    v1 = 0;
    #3;
    clear_model();
    rst_n = 1;
    @(posedge clk);
    #1;

    // single write then read back
    req(0, 1, 16'd5, 16'hBEEF, 0);
    req(0, 0, 16'd5, 16'h0000, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("mem5_written", mem[5], 16'hBEEF);

    // contention after reset: strict alternation with held valids
    do_reset();
    fork
      begin req(0, 0, 16'd10, 0, 0); req(0, 0, 16'd11, 0, 0); end
      begin req(1, 0, 16'd12, 0, 0); req(1, 0, 16'd13, 0, 0); end
    join
    chk("contention_count", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("contention_g0", grants[0], 0);
      chk("contention_g1", grants[1], 1);
      chk("contention_g2", grants[2], 0);
      chk("contention_g3", grants[3], 1);
    end

    // out-of-range accesses
    old0 = mem[0];
    req(1, 1, 16'd1024, 16'h1234, 0);
    req(1, 0, 16'hFFFF, 16'h0000, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("oor_mem0", mem[0], old0);

    // reset during ACCESS of a write
    old7 = mem[7];
    req(0, 1, 16'd7, 16'hA5A5, 0);
    v0 = 1;
    rst_n = 0;
    #1;
    chk("midrst_ready0", ready0, 0);
    chk("midrst_wen", mem_wen, 0);
    chk("midrst_rvalid", {rvalid0, rvalid1}, 0);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    clear_model();
    ref_mem[7] = old7;
    v0 = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_mem7", mem[7], old7);

    // lock sequence
    do_reset();
    fork
      begin
        req(1, 0, 16'd20, 0, 1);
        req(1, 0, 16'd21, 0, 1);
        req(1, 0, 16'd22, 0, 0);
      end
      begin
        @(posedge clk);
        #1;
        req(0, 0, 16'd23, 0, 0);
      end
    join
`ifdef RISC16_ARB_LOCK_EN
    exp_seq = '{1, 1, 1, 0};
`else
    exp_seq = '{1, 0, 1, 1};
`endif
    chk("lock_count", grants.size(), 4);
    if (grants.size() == 4)
      for (int i = 0; i < 4; i++) chk("lock_seq", grants[i], exp_seq[i]);

    // back-to-back reads
    repeat (3) @(posedge clk);
    #1;
    hs_cyc.delete();
    req(0, 0, 16'd1, 0, 0);
    req(0, 0, 16'd2, 0, 0);
    req(0, 0, 16'd3, 0, 0);
    chk("b2b_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], 3);
      chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], 3);
    end

    // randomized contention
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (6) @(posedge clk);
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_wq", wq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
